mac_pkt_buf_wbs: RTL
====================

Name: mac_pkt_buf_wbs

Overview:
Dual-port Wishbone slave packet-buffer responder, i.e. the memory end of the GMAC TX-read and RX-write DMA masters.
- Holds a word-addressed 32-bit buffer and arbitrates between the two masters with a round-robin arbiter.
- Generates byte-select-qualified responses with a configurable wait state.
- Produces the TX/RX descriptor queue-counter inc/dec pulses that feed the MAC.
- Sits between the GMAC wrapper masters and the MAC qcnt inputs, replacing ad-hoc qcnt decode in the interconnect.

Parameters:
DEPTH, 1024, buffer size in 32-bit words (power of 2, max 16384).
WAIT_CYC, 0, extra wait cycles inserted before ack (0..7).

Ports:
app_clk  input  1  sole clock, all logic rising-edge.
reset  input  1  synchronous, active-high reset.
s0_adr_i  input  16  port0 (GMAC TX master) byte address.
s0_dat_i  input  32  port0 write data.
s0_sel_i  input  4  port0 byte enables.
s0_we_i  input  1  port0 write enable.
s0_stb_i  input  1  port0 strobe.
s0_cyc_i  input  1  port0 cycle.
s0_dat_o  output  32  port0 read data.
s0_ack_o  output  1  port0 ack.
s0_err_o  output  1  port0 error (out-of-range address).
s1_*  same set as s0_*  port1 (GMAC RX master).
cfg_tx_qbase_addr  input  10  TX descriptor queue base, compared to adr[15:6].
cfg_rx_qbase_addr  input  10  RX descriptor queue base, compared to adr[15:6].
mac_tx_qcnt_inc  output  1  one-cycle pulse.
mac_tx_qcnt_dec  output  1  one-cycle pulse.
mac_rx_qcnt_inc  output  1  one-cycle pulse.
mac_rx_qcnt_dec  output  1  one-cycle pulse.

Behaviour:
- Reset: FSM=IDLE; all ack/err/qcnt outputs 0; sN_dat_o=0; last_grant=1 so port0 wins first. Buffer contents are not reset.
- Request: reqN = sN_cyc_i & sN_stb_i.
- FSM IDLE:
  - Any req: latch grant, go to WAIT (wait counter = WAIT_CYC).
  - Both req: grant the port != last_grant.
- FSM WAIT: decrement counter; at 0 go to RESP. With WAIT_CYC=0, WAIT is skipped (IDLE -> RESP).
- FSM RESP:
  - Assert ack or err of the granted port for exactly 1 cycle.
  - Update last_grant; return to IDLE.
  - The next grant is possible in the cycle after RESP (2-cycle minimum per access).
- Latency: req sampled in IDLE at cycle N gives ack at N+1+WAIT_CYC.
- Abort: if the granted reqN drops in WAIT or RESP, go to IDLE with no ack, no write and no qcnt pulse.
- Address: word index = adr[15:2].
  - If index >= DEPTH: err instead of ack, no write, dat_o unchanged, no qcnt pulse.
- Write (in RESP cycle): for each sel bit set, update the corresponding byte lane. sel=0 acks with no change.
- Read: sN_dat_o is loaded from the buffer so it is valid in the ack cycle and held until the next read ack to that port. Unselected lanes still return stored data.
- Qcnt pulses are asserted in the ack cycle only, and only when all of: adr[15:6]==cfg_*_qbase_addr, sel[3]=1, ack (not err).
  - Write gives inc; read gives dec.
  - If TX and RX bases are equal, both TX and RX pulses fire.
  - Only one access completes per cycle, so inc and dec for the same queue are never simultaneous.
- Reset mid-access: reset wins; no ack, no write, no pulse.
- cfg_*_qbase_addr is sampled in the RESP cycle (not latched at grant).

Decomposition:
- Shared package mac_pkg holds: pbuf_state_e {IDLE, WAIT, RESP}; port-id typedef; constants for the QBASE_LSB=6 and word-offset LSB=2 address slices.
- One sub-module: mac_pbuf_rr_arb (2-requester round-robin, last_grant register, grant valid only in IDLE).

Test Plan:
- Single write then read, WAIT_CYC=0, s0 adr 0x0010, dat 0xA5A5_1234, sel F: ack 1 cycle after req; read returns 0xA5A5_1234.
- Byte lanes: write 0xFFFF_FFFF with sel F, then 0x0000_0000 with sel 0x5; read gives 0xFF00_FF00.
- Contention: s0 and s1 req in the same cycle from reset: s0 acked first, s1 next; repeat with both held gives strict alternation.
- Qcnt: cfg_tx_qbase=0x004, s1 write adr 0x0100 sel 8 gives one mac_tx_qcnt_inc pulse; s0 read same address gives one mac_tx_qcnt_dec; sel 7 gives no pulse.
- Error/abort: DEPTH=1024, adr 0x1000 gives err, no ack, no pulse. With WAIT_CYC=3, drop stb after 1 cycle: no ack, memory unchanged.
- Reset asserted in WAIT: outputs 0 next cycle; a following request is served by port0.

Source files
------------

// File: rtl/mac_pkg.sv
// Packet-buffer Wishbone slave shared types.
// FSM states, port ids and address slice positions.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } pbuf_state_e;

  typedef enum logic {
    P0,
    P1
  } port_id_e;

  localparam int QBASE_LSB = 6;
  localparam int WOFF_LSB  = 2;

endpackage

// File: rtl/mac_pbuf_rr_arb.sv
// Two-requester round-robin arbiter for the packet buffer.
// Grant is only meaningful while the slave FSM is idle.
module mac_pbuf_rr_arb
  import mac_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     idle,
  input  logic     req0,
  input  logic     req1,
  input  logic     upd,
  input  port_id_e upd_id,
  output port_id_e gnt,
  output logic     gnt_vld
);

  port_id_e last_q;

  // Reset to P1 so port0 wins the first contended grant
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= P1;
    end else if (upd) begin
      last_q <= upd_id;
    end
  end

  always_comb begin
    gnt_vld = idle & (req0 | req1);
    gnt     = P0;
    unique case ({req1, req0})
      2'b11:   gnt = (last_q == P0) ? P1 : P0;
      2'b10:   gnt = P1;
      default: gnt = P0;
    endcase
  end

endmodule

// File: rtl/mac_pkt_buf_wbs.sv
// Dual-port Wishbone packet buffer with round-robin access,
// wait states and TX/RX descriptor queue-counter pulses.
module mac_pkt_buf_wbs
  import mac_pkg::*;
#(
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned WAIT_CYC = 0
) (
  input  logic        app_clk,
  input  logic        reset,
  input  logic [15:0] s0_adr_i,
  input  logic [31:0] s0_dat_i,
  input  logic [3:0]  s0_sel_i,
  input  logic        s0_we_i,
  input  logic        s0_stb_i,
  input  logic        s0_cyc_i,
  output logic [31:0] s0_dat_o,
  output logic        s0_ack_o,
  output logic        s0_err_o,
  input  logic [15:0] s1_adr_i,
  input  logic [31:0] s1_dat_i,
  input  logic [3:0]  s1_sel_i,
  input  logic        s1_we_i,
  input  logic        s1_stb_i,
  input  logic        s1_cyc_i,
  output logic [31:0] s1_dat_o,
  output logic        s1_ack_o,
  output logic        s1_err_o,
  input  logic [9:0]  cfg_tx_qbase_addr,
  input  logic [9:0]  cfg_rx_qbase_addr,
  output logic        mac_tx_qcnt_inc,
  output logic        mac_tx_qcnt_dec,
  output logic        mac_rx_qcnt_inc,
  output logic        mac_rx_qcnt_dec
);

  localparam int unsigned IW = $clog2(DEPTH);

  logic        req0, req1;
  pbuf_state_e state, state_nx;
  logic [2:0]  cnt, cnt_nx;
  port_id_e    gnt_q, gnt_nx, arb_gnt, cur;
  logic        arb_vld;
  logic [15:0] adr_c;
  logic [31:0] dat_c;
  logic [3:0]  sel_c;
  logic        we_c, req_c;
  logic [13:0] word;
  logic        in_range;
  logic [IW-1:0] idx;
  logic [31:0] mem [DEPTH];
  logic [31:0] rd_q, hold0, hold1;
  logic        done, ack_any, err_any;
  logic        rd_ack0, rd_ack1;
  logic        tx_hit, rx_hit;

  assign req0 = s0_cyc_i & s0_stb_i;
  assign req1 = s1_cyc_i & s1_stb_i;

  mac_pbuf_rr_arb u_arb (
    .clk     (app_clk),
    .reset   (reset),
    .idle    (state == IDLE),
    .req0    (req0),
    .req1    (req1),
    .upd     (done),
    .upd_id  (gnt_q),
    .gnt     (arb_gnt),
    .gnt_vld (arb_vld)
  );

  // In IDLE the arbiter picks the port; afterwards the latched grant
  always_comb begin
    cur = (state == IDLE) ? arb_gnt : gnt_q;
    if (cur == P1) begin
      adr_c = s1_adr_i;
      dat_c = s1_dat_i;
      sel_c = s1_sel_i;
      we_c  = s1_we_i;
      req_c = req1;
    end else begin
      adr_c = s0_adr_i;
      dat_c = s0_dat_i;
      sel_c = s0_sel_i;
      we_c  = s0_we_i;
      req_c = req0;
    end
  end

  assign word     = adr_c[15:WOFF_LSB];
  assign in_range = {1'b0, word} < 15'(DEPTH);
  assign idx      = word[IW-1:0];

  assign done    = (state == RESP) & req_c & ~reset;
  assign ack_any = done & in_range;
  assign err_any = done & ~in_range;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    gnt_nx   = gnt_q;
    unique case (state)
      IDLE: begin
        if (arb_vld) begin
          gnt_nx = arb_gnt;
          if (WAIT_CYC == 0) begin
            state_nx = RESP;
          end else begin
            state_nx = WAIT;
            cnt_nx   = 3'(WAIT_CYC - 1);
          end
        end
      end
      WAIT: begin
        if (!req_c) begin
          state_nx = IDLE;
        end else if (cnt == 3'd0) begin
          state_nx = RESP;
        end else begin
          cnt_nx = cnt - 3'd1;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge app_clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 3'd0;
      gnt_q <= P0;
      hold0 <= 32'd0;
      hold1 <= 32'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      gnt_q <= gnt_nx;
      if (rd_ack0) hold0 <= rd_q;
      if (rd_ack1) hold1 <= rd_q;
    end
  end

  // Prefetch on RESP entry so read data is ready in the ack cycle
  always_ff @(posedge app_clk) begin
    if (state_nx == RESP) rd_q <= mem[idx];
    if (ack_any && we_c) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_c[b]) mem[idx][8*b +: 8] <= dat_c[8*b +: 8];
      end
    end
  end

  assign rd_ack0 = ack_any & ~we_c & (gnt_q == P0);
  assign rd_ack1 = ack_any & ~we_c & (gnt_q == P1);

  assign s0_ack_o = ack_any & (gnt_q == P0);
  assign s1_ack_o = ack_any & (gnt_q == P1);
  assign s0_err_o = err_any & (gnt_q == P0);
  assign s1_err_o = err_any & (gnt_q == P1);
  assign s0_dat_o = rd_ack0 ? rd_q : hold0;
  assign s1_dat_o = rd_ack1 ? rd_q : hold1;

  assign tx_hit = ack_any & sel_c[3] &
                  (adr_c[15:QBASE_LSB] == cfg_tx_qbase_addr);
  assign rx_hit = ack_any & sel_c[3] &
                  (adr_c[15:QBASE_LSB] == cfg_rx_qbase_addr);

  assign mac_tx_qcnt_inc = tx_hit & we_c;
  assign mac_tx_qcnt_dec = tx_hit & ~we_c;
  assign mac_rx_qcnt_inc = rx_hit & we_c;
  assign mac_rx_qcnt_dec = rx_hit & ~we_c;

endmodule
